// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   state_t     : receiver FSM state encoding
//   PARITY_*    : values accepted by the PARITY_MODE parameter
//   maj3        : 3-input majority, used by the optional sample voter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end for uart_rx_param.
// Two-flop synchroniser on the raw serial line, plus an optional 3-tap
// majority voter (macro UART_RX_MAJORITY_EN) over the last three ticks.
// Ports:
//   i_clock, i_reset : system clock, async active-high reset
//   i_tick           : oversample tick enable
//   i_bit_rx         : raw serial line (async)
//   o_rx             : synchronised line level (used for idle/arm logic)
//   o_sample         : value to use at a sample point (voted or plain)
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_bit_rx,
  output logic o_rx,
  output logic o_sample
);

  logic [1:0] sync;

  // Resets to idle-high so a reset never looks like a start edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) sync <= 2'b11;
    else         sync <= {sync[0], i_bit_rx};
  end

  assign o_rx = sync[1];

`ifdef UART_RX_MAJORITY_EN
  // hist[0] = rx at the previous tick, hist[1] = two ticks back; together
  // with the current rx this covers the three ticks ending at the sample.
  logic [1:0] hist;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)     hist <= 2'b11;
    else if (i_tick) hist <= {hist[0], o_rx};
  end

  assign o_sample = maj3(hist[1], hist[0], o_rx);
`else
  logic unused_tick;
  assign unused_tick = i_tick;
  assign o_sample    = o_rx;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (LSB first, optional parity, 1 or 2 stop bits).
// Optional build macro: UART_RX_MAJORITY_EN (3-tick majority at every
// sample point; timing identical either way).
// Ports:
//   i_clock, i_reset : system clock, async active-high reset
//   i_tick           : one-clock enable, OVERSAMPLE per bit
//   i_bit_rx         : serial line, idle high
//   i_rd             : consumer acknowledge of o_data_out
//   o_data_out       : last received word
//   o_rx_done        : one-clock pulse on frame completion
//   o_valid          : word pending, cleared by i_rd
//   o_parity_err     : parity flag of o_data_out
//   o_frame_err      : stop-bit flag of o_data_out
//   o_overrun_err    : sticky, frame landed while o_valid was high
//   o_busy           : FSM not in IDLE
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int WIDTH_WORD    = 8,
  parameter int CANT_BIT_STOP = 2,
  parameter int OVERSAMPLE    = 16,
  parameter int PARITY_MODE   = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_bit_rx,
  input  logic                  i_rd,
  output logic [WIDTH_WORD-1:0] o_data_out,
  output logic                  o_rx_done,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_overrun_err,
  output logic                  o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH_WORD + 1);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH_WORD - 1);
  localparam logic [BW-1:0] S_LAST = BW'(CANT_BIT_STOP - 1);
  localparam logic          P_ODD  = (PARITY_MODE == PARITY_ODD);

  state_t                state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [WIDTH_WORD-1:0] buffer;
  logic                  armed;
  logic                  par_err;
  logic                  rx;
  logic                  sample;

  uart_rx_sampler u_sampler (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_tick   (i_tick),
    .i_bit_rx (i_bit_rx),
    .o_rx     (rx),
    .o_sample (sample)
  );

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      buffer        <= '0;
      armed         <= 1'b1;
      par_err       <= 1'b0;
      o_data_out    <= '0;
      o_rx_done     <= 1'b0;
      o_valid       <= 1'b0;
      o_parity_err  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_overrun_err <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;

      // Handshake runs every clock; a finish below overrides it so that a
      // coinciding new frame keeps o_valid high.
      if (i_rd && o_valid) begin
        o_valid       <= 1'b0;
        o_overrun_err <= 1'b0;
      end

      if (i_tick) begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            if (rx)         armed <= 1'b1;
            else if (armed) state <= START;
          end

          START: begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= sample ? IDLE : DATA;  // high mid-start = glitch
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              buffer   <= {sample, buffer[WIDTH_WORD-1:1]};
              if (bit_cnt == B_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          PARITY: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              par_err  <= (^buffer) ^ sample ^ P_ODD;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          STOP: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              if (!sample || bit_cnt == S_LAST) begin
                o_data_out   <= buffer;
                o_parity_err <= par_err;
                o_frame_err  <= !sample;
                o_rx_done    <= 1'b1;
                o_valid      <= 1'b1;
                if (o_valid && !i_rd) o_overrun_err <= 1'b1;
                // A low stop bit may be a break: stay disarmed until the
                // line has been seen high again.
                if (!sample) armed <= 1'b0;
                bit_cnt <= '0;
                state   <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
